// File: rtl/cc_branch_pkg.sv
// Shared definitions for the integer condition-code / Bicc branch unit.
//   - Bicc cond field encodings (BN..BVC)
//   - branch FSM state encoding
//   - bit positions of the {Z,N,C,V} flags inside the 4-bit flag vector
package cc_branch_pkg;

  // Bicc cond field encodings; 8..F are the complements of 0..7
  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  // Flag bit indices, matching the ALU flag output ordering
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Delay-slot tracking FSM
  typedef enum logic [1:0] {
    StNormal    = 2'd0,
    StDelaySlot = 2'd1,
    StAnnulSlot = 2'd2
  } br_state_e;

endpackage

// File: rtl/bicc_cond_eval.sv
// Purely combinational Bicc condition evaluator.
// Ports:
//   cond     in  4  Bicc cond field
//   icc_eff  in  4  effective condition codes {Z,N,C,V}
//   taken    out 1  condition holds
module bicc_cond_eval
  import cc_branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc_eff,
  output logic       taken
);

  logic z, n, c, v;

  always_comb begin
    z = icc_eff[FLAG_Z];
    n = icc_eff[FLAG_N];
    c = icc_eff[FLAG_C];
    v = icc_eff[FLAG_V];
  end

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_BN:   taken = 1'b0;
      COND_BE:   taken = z;
      COND_BLE:  taken = z | (n ^ v);
      COND_BL:   taken = n ^ v;
      COND_BLEU: taken = c | z;
      COND_BCS:  taken = c;
      COND_BNEG: taken = n;
      COND_BVS:  taken = v;
      COND_BA:   taken = 1'b1;
      COND_BNE:  taken = ~z;
      COND_BG:   taken = ~(z | (n ^ v));
      COND_BGE:  taken = ~(n ^ v);
      COND_BGU:  taken = ~(c | z);
      COND_BCC:  taken = ~c;
      COND_BPOS: taken = ~n;
      COND_BVC:  taken = ~v;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_branch_unit.sv
// Integer condition-code register and Bicc branch resolver.
// Latches ALU flags for cc-setting instructions, resolves the Bicc in ID (with
// forwarding from EX) and tracks the delay slot for annul and DCTI detection.
// Optional feature: define CC_BRANCH_STATS_EN to add saturating taken/annul counters.
// Ports:
//   clk        in   1       clock, all state on posedge
//   reset      in   1       synchronous reset, active-high
//   alu_flags  in   FLAG_W  ALU flags {Z,N,C,V} of the EX instruction
//   cc_we      in   1       EX instruction writes icc
//   stall      in   1       pipeline hold, freezes all state
//   br_valid   in   1       Bicc present in ID
//   br_cond    in   COND_W  Bicc cond field
//   br_annul   in   1       Bicc annul bit
//   icc        out  FLAG_W  registered condition codes
//   br_taken   out  1       combinational taken decision
//   squash     out  1       delay-slot instruction must be annulled
//   dcti_err   out  1       1-cycle pulse: Bicc found in a live delay slot
//   taken_cnt  out  CNT_W   (stats only) saturating count of taken branches
//   annul_cnt  out  CNT_W   (stats only) saturating count of annulled slots
module cc_branch_unit
  import cc_branch_pkg::*;
#(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned COND_W = 4
`ifdef CC_BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              cc_we,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic              br_annul,
  output logic [FLAG_W-1:0] icc,
  output logic              br_taken,
  output logic              squash,
  output logic              dcti_err
`ifdef CC_BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  annul_cnt
`endif
);

  logic [FLAG_W-1:0] icc_q;
  logic [FLAG_W-1:0] icc_eff;
  br_state_e         state_q;
  logic              dcti_err_q;
  logic              cond_true;
  logic              annul;

  // Forward the EX flags so a cc-setter followed by a Bicc needs no bubble
  always_comb begin
    icc_eff = cc_we ? alu_flags : icc_q;
  end

  bicc_cond_eval u_cond_eval (
    .cond    (br_cond),
    .icc_eff (icc_eff),
    .taken   (cond_true)
  );

  // BA,a annuls even though taken; every other ",a" annuls only when untaken
  always_comb begin
    annul    = br_annul & (~cond_true | (br_cond == COND_BA));
    // Only a Bicc decoded in NORMAL is a real branch; slot-resident ones are ignored
    br_taken = br_valid & ~stall & (state_q == StNormal) & cond_true;
  end

`ifdef CC_BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] annul_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      icc_q      <= '0;
      state_q    <= StNormal;
      dcti_err_q <= 1'b0;
`ifdef CC_BRANCH_STATS_EN
      taken_cnt_q <= '0;
      annul_cnt_q <= '0;
`endif
    end else if (stall) begin
      // Everything holds except the error pulse, which must not stretch
      dcti_err_q <= 1'b0;
    end else begin
      if (cc_we) begin
        icc_q <= alu_flags;
      end
      dcti_err_q <= br_valid & (state_q == StDelaySlot);
      unique case (state_q)
        StNormal: begin
          if (br_valid) begin
            state_q <= annul ? StAnnulSlot : StDelaySlot;
          end
        end
        StDelaySlot: state_q <= StNormal;
        StAnnulSlot: state_q <= StNormal;
        default:     state_q <= StNormal;
      endcase
`ifdef CC_BRANCH_STATS_EN
      if (br_taken && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 1'b1;
      end
      if ((state_q == StNormal) && br_valid && annul && (annul_cnt_q != '1)) begin
        annul_cnt_q <= annul_cnt_q + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    icc      = icc_q;
    squash   = (state_q == StAnnulSlot);
    dcti_err = dcti_err_q;
  end

`ifdef CC_BRANCH_STATS_EN
  always_comb begin
    taken_cnt = taken_cnt_q;
    annul_cnt = annul_cnt_q;
  end
`endif

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed self-checking bench for cc_branch_unit.
module tb_cc_branch_unit;

  logic       clk;
  logic       reset;
  logic [3:0] alu_flags;
  logic       cc_we;
  logic       stall;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [3:0] icc;
  logic       br_taken;
  logic       squash;
  logic       dcti_err;
`ifdef CC_BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] annul_cnt;
`endif

  int checks;
  int failures;

  cc_branch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .alu_flags (alu_flags),
    .cc_we     (cc_we),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_annul  (br_annul),
    .icc       (icc),
    .br_taken  (br_taken),
    .squash    (squash),
    .dcti_err  (dcti_err)
`ifdef CC_BRANCH_STATS_EN
    ,
    .taken_cnt (taken_cnt),
    .annul_cnt (annul_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [3:0] cond, input logic a);
    br_valid = 1'b1;
    br_cond  = cond;
    br_annul = a;
  endtask

  // {flags, cond, expected taken} with forwarded flags
  localparam logic [8:0] VEC [14] = '{
    {4'b0011, 4'h2, 1'b1}, {4'b0011, 4'hA, 1'b0}, {4'b0101, 4'h3, 1'b0},
    {4'b0101, 4'hB, 1'b1}, {4'b0000, 4'h4, 1'b0}, {4'b0010, 4'hC, 1'b0},
    {4'b0000, 4'hC, 1'b1}, {4'b0010, 4'hD, 1'b0}, {4'b0010, 4'h5, 1'b1},
    {4'b0100, 4'hE, 1'b0}, {4'b0001, 4'h7, 1'b1}, {4'b0001, 4'hF, 1'b0},
    {4'b1000, 4'h9, 1'b0}, {4'b0000, 4'h6, 1'b0}
  };

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    alu_flags = 4'b1000;
    cc_we     = 1'b1;
    stall     = 1'b0;
    br_valid  = 1'b0;
    br_cond   = 4'h0;
    br_annul  = 1'b0;

    // Reset wins over a pending cc write
    tick();
    tick();
    check_eq("reset_icc", icc, 4'b0000);
    check_eq("reset_squash", squash, 1'b0);
    check_eq("reset_dcti", dcti_err, 1'b0);
`ifdef CC_BRANCH_STATS_EN
    check_eq("reset_taken_cnt", taken_cnt, 16'h0);
    check_eq("reset_annul_cnt", annul_cnt, 16'h0);
`endif
    reset = 1'b0;
    tick();
    check_eq("icc_load", icc, 4'b1000);

    // Forwarded BL: N^V from new flags is 1, from old icc it would be 0
    alu_flags = 4'b0100;
    branch(4'h3, 1'b0);
    #1;
    check_eq("fwd_bl_taken", br_taken, 1'b1);
    check_eq("fwd_icc_old", icc, 4'b1000);
    tick();
    cc_we    = 1'b0;
    br_valid = 1'b0;
    check_eq("fwd_icc_new", icc, 4'b0100);
    check_eq("fwd_no_squash", squash, 1'b0);
    tick();

    // Condition table, each branch followed by its slot
    for (int i = 0; i < 14; i++) begin
      cc_we     = 1'b1;
      alu_flags = VEC[i][8:5];
      branch(VEC[i][4:1], 1'b0);
      #1;
      check_eq($sformatf("cond_%0d", i), br_taken, VEC[i][0]);
      tick();
      cc_we    = 1'b0;
      br_valid = 1'b0;
      check_eq($sformatf("cond_icc_%0d", i), icc, VEC[i][8:5]);
      tick();
    end

    // Clear icc
    cc_we     = 1'b1;
    alu_flags = 4'b0000;
    tick();
    cc_we = 1'b0;

    // BE,a untaken: slot annulled; a Bicc in the annulled slot is ignored
    branch(4'h1, 1'b1);
    #1;
    check_eq("bea_taken", br_taken, 1'b0);
    tick();
    branch(4'h8, 1'b0);
    #1;
    check_eq("bea_squash", squash, 1'b1);
    check_eq("annulled_bicc_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    check_eq("bea_squash_clear", squash, 1'b0);
    check_eq("annulled_no_dcti", dcti_err, 1'b0);

    // BA,a: taken and annulled
    branch(4'h8, 1'b1);
    #1;
    check_eq("baa_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    check_eq("baa_squash", squash, 1'b1);
    tick();
    check_eq("baa_squash_clear", squash, 1'b0);

    // BA without annul
    branch(4'h8, 1'b0);
    #1;
    check_eq("ba_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    check_eq("ba_no_squash", squash, 1'b0);
    tick();

    // BN,a annuls
    branch(4'h0, 1'b1);
    #1;
    check_eq("bna_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    check_eq("bna_squash", squash, 1'b1);
    tick();

    // BNE taken, then stall in the delay slot with a Bicc waiting there
    branch(4'h9, 1'b0);
    #1;
    check_eq("bne_taken", br_taken, 1'b1);
    tick();
    stall = 1'b1;
    branch(4'h8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("stall_taken_%0d", i), br_taken, 1'b0);
      tick();
      check_eq($sformatf("stall_squash_%0d", i), squash, 1'b0);
      check_eq($sformatf("stall_dcti_%0d", i), dcti_err, 1'b0);
    end
    stall = 1'b0;
    #1;
    check_eq("slot_bicc_taken", br_taken, 1'b0);
    tick();
    br_valid = 1'b0;
    check_eq("dcti_pulse", dcti_err, 1'b1);
    tick();
    check_eq("dcti_clear", dcti_err, 1'b0);
    branch(4'h8, 1'b0);
    #1;
    check_eq("after_slot_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    tick();

    // Stall holds squash and icc even with a cc write pending
    branch(4'h1, 1'b1);
    tick();
    br_valid  = 1'b0;
    stall     = 1'b1;
    cc_we     = 1'b1;
    alu_flags = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_hold_squash_%0d", i), squash, 1'b1);
      check_eq($sformatf("stall_hold_icc_%0d", i), icc, 4'b0000);
    end
    stall = 1'b0;
    cc_we = 1'b0;
    tick();
    check_eq("stall_release_squash", squash, 1'b0);
    check_eq("stall_release_icc", icc, 4'b0000);

    // Reset mid-branch overrides stall
    cc_we     = 1'b1;
    alu_flags = 4'b1010;
    tick();
    cc_we = 1'b0;
    branch(4'h0, 1'b1);
    tick();
    br_valid = 1'b0;
    check_eq("pre_reset_squash", squash, 1'b1);
    reset     = 1'b1;
    stall     = 1'b1;
    cc_we     = 1'b1;
    alu_flags = 4'b0110;
    tick();
    check_eq("mid_reset_squash", squash, 1'b0);
    check_eq("mid_reset_icc", icc, 4'b0000);
    reset = 1'b0;
    stall = 1'b0;
    cc_we = 1'b0;
    branch(4'h8, 1'b0);
    #1;
    check_eq("post_reset_taken", br_taken, 1'b1);
    tick();
    br_valid = 1'b0;
    tick();

`ifdef CC_BRANCH_STATS_EN
    // One taken BA above since reset; add two more plus one annulled BN,a
    for (int i = 0; i < 2; i++) begin
      branch(4'h8, 1'b0);
      tick();
      br_valid = 1'b0;
      tick();
    end
    branch(4'h0, 1'b1);
    tick();
    br_valid = 1'b0;
    tick();
    check_eq("stats_taken_cnt", taken_cnt, 16'd3);
    check_eq("stats_annul_cnt", annul_cnt, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stats_clear_taken", taken_cnt, 16'd0);
    check_eq("stats_clear_annul", annul_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
